// File: rtl/bit_sel_window_ctrl_pkg.sv
// Shared types and constants for the bit-select window controller.
// Holds the FSM state enum, window geometry and the offset-to-selector-command encoding.
package bit_sel_window_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int MAX_WIN        = 5;
  localparam int OUT_DATA_WIDTH = 4;
  localparam int RES_WIDTH      = MAX_WIN * OUT_DATA_WIDTH;

  // Offset 0 is the selector's pass-through command; offsets 1..4 set the MSB and carry s-1.
  function automatic logic [2:0] offset_to_cmd(input logic [2:0] s);
    if (s == 3'd0) return 3'b000;
    return {1'b1, 2'(s - 3'd1)};
  endfunction

endpackage

// File: rtl/bit_sel_window_ctrl_if.sv
// Request, selector-datapath and result signals of the window controller.
// The slave modport is the controller's view; master is the environment's view.
interface bit_sel_window_ctrl_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int OUT_DATA_WIDTH = 4,
  parameter int COMMAND_WIDTH  = 3,
  parameter int RES_WIDTH      = 20
);
  logic                      i_req_valid;
  logic                      o_req_ready;
  logic [DATA_WIDTH-1:0]     i_req_data;
  logic [2:0]                i_req_start;
  logic [2:0]                i_req_num;
  logic                      o_dp_valid;
  logic [DATA_WIDTH-1:0]     o_dp_data;
  logic                      o_dp_en;
  logic [COMMAND_WIDTH-1:0]  o_dp_cmd;
  logic                      i_dp_valid;
  logic [OUT_DATA_WIDTH-1:0] i_dp_data;
  logic                      o_res_valid;
  logic                      i_res_ready;
  logic [RES_WIDTH-1:0]      o_res_data;
  logic [2:0]                o_res_cnt;
  logic                      o_res_err;

  modport slave (
    input  i_req_valid, i_req_data, i_req_start, i_req_num,
    input  i_dp_valid, i_dp_data, i_res_ready,
    output o_req_ready, o_dp_valid, o_dp_data, o_dp_en, o_dp_cmd,
    output o_res_valid, o_res_data, o_res_cnt, o_res_err
  );

  modport master (
    output i_req_valid, i_req_data, i_req_start, i_req_num,
    output i_dp_valid, i_dp_data, i_res_ready,
    input  o_req_ready, o_dp_valid, o_dp_data, o_dp_en, o_dp_cmd,
    input  o_res_valid, o_res_data, o_res_cnt, o_res_err
  );
endinterface

// File: rtl/bit_sel_window_ctrl.sv
// Sequences an external 1-cycle bit selector over consecutive offsets of a latched word
// and packs the returned nibbles into one result held until consumed.
//
// state    | meaning
// ST_IDLE  | ready for a request
// ST_ISSUE | one selector command per cycle, offsets start..start+N-1
// ST_DRAIN | one cycle to catch the last selector return
// ST_HOLD  | result presented until i_res_ready
module bit_sel_window_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int OUT_DATA_WIDTH = bit_sel_window_ctrl_pkg::OUT_DATA_WIDTH,
  parameter int COMMAND_WIDTH  = 3,
  parameter int MAX_WIN        = bit_sel_window_ctrl_pkg::MAX_WIN
) (
  input logic clk,
  input logic rst_n,
  bit_sel_window_ctrl_if.slave bus
);
  import bit_sel_window_ctrl_pkg::*;

  localparam int RES_W = MAX_WIN * OUT_DATA_WIDTH;

  state_e                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    word_q, word_d;
  logic [2:0]               start_q, start_d;
  logic [2:0]               num_q, num_d;
  logic [2:0]               k_q, k_d;
  logic [2:0]               cap_q, cap_d;
  logic                     req_ready_q, req_ready_d;
  logic                     dp_valid_q, dp_valid_d;
  logic [COMMAND_WIDTH-1:0] dp_cmd_q, dp_cmd_d;
  logic                     res_valid_q, res_valid_d;
  logic [RES_W-1:0]         res_data_q, res_data_d;
  logic [2:0]               res_cnt_q, res_cnt_d;
  logic                     res_err_q, res_err_d;
  logic [2:0]               avail;
  logic                     capture;

  assign avail   = 3'(MAX_WIN) - bus.i_req_start;
  assign capture = bus.i_dp_valid && (state_q == ST_ISSUE || state_q == ST_DRAIN);

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    start_d     = start_q;
    num_d       = num_q;
    k_d         = k_q;
    cap_d       = cap_q;
    req_ready_d = 1'b0;
    dp_valid_d  = 1'b0;
    dp_cmd_d    = '0;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_cnt_d   = res_cnt_q;
    res_err_d   = res_err_q;

    // Extra returns beyond the result width still count, so the mismatch flags an error.
    if (capture) begin
      if (cap_q < 3'(MAX_WIN))
        res_data_d[OUT_DATA_WIDTH*cap_q +: OUT_DATA_WIDTH] = bus.i_dp_data;
      if (cap_q != 3'd7) cap_d = cap_q + 3'd1;
    end

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (bus.i_req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          word_d      = bus.i_req_data;
          start_d     = bus.i_req_start;
          k_d         = 3'd0;
          cap_d       = 3'd0;
          res_data_d  = '0;
          if (bus.i_req_start > 3'(MAX_WIN - 1) || bus.i_req_num == 3'd0) begin
            state_d     = ST_HOLD;
            num_d       = 3'd0;
            res_valid_d = 1'b1;
            res_cnt_d   = 3'd0;
            res_err_d   = 1'b1;
          end else begin
            state_d    = ST_ISSUE;
            num_d      = (bus.i_req_num < avail) ? bus.i_req_num : avail;
            dp_valid_d = 1'b1;
            dp_cmd_d   = offset_to_cmd(bus.i_req_start);
          end
        end
      end
      ST_ISSUE: begin
        if (k_q == num_q - 3'd1) begin
          state_d = ST_DRAIN;
        end else begin
          k_d        = k_q + 3'd1;
          dp_valid_d = 1'b1;
          dp_cmd_d   = offset_to_cmd(3'(start_q + k_q + 3'd1));
        end
      end
      ST_DRAIN: begin
        state_d     = ST_HOLD;
        res_valid_d = 1'b1;
        res_cnt_d   = num_q;
        res_err_d   = (cap_d != num_q);
      end
      ST_HOLD: begin
        if (bus.i_res_ready) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          res_data_d  = '0;
          res_cnt_d   = 3'd0;
          res_err_d   = 1'b0;
        end else begin
          res_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      start_q     <= '0;
      num_q       <= '0;
      k_q         <= '0;
      cap_q       <= '0;
      req_ready_q <= 1'b0;
      dp_valid_q  <= 1'b0;
      dp_cmd_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_cnt_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      start_q     <= start_d;
      num_q       <= num_d;
      k_q         <= k_d;
      cap_q       <= cap_d;
      req_ready_q <= req_ready_d;
      dp_valid_q  <= dp_valid_d;
      dp_cmd_q    <= dp_cmd_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_cnt_q   <= res_cnt_d;
      res_err_q   <= res_err_d;
    end
  end

  assign bus.o_req_ready = req_ready_q;
  assign bus.o_dp_valid  = dp_valid_q;
  assign bus.o_dp_en     = dp_valid_q;
  assign bus.o_dp_cmd    = dp_cmd_q;
  assign bus.o_dp_data   = word_q;
  assign bus.o_res_valid = res_valid_q;
  assign bus.o_res_data  = res_data_q;
  assign bus.o_res_cnt   = res_cnt_q;
  assign bus.o_res_err   = res_err_q;

endmodule

// File: tb/tb_bit_sel_window_ctrl.sv
// Bench for bit_sel_window_ctrl: behavioural selector, directed V1-V6 cases and
// randomized requests compared cycle by cycle against an arithmetic reference model.
module tb_bit_sel_window_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  bit_sel_window_ctrl_if bus ();

  bit_sel_window_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Selector: 1-cycle latency, output = bits [3:0] of (data >> offset decoded from cmd).
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.i_dp_valid <= 1'b0;
      bus.i_dp_data  <= '0;
    end else begin
      bus.i_dp_valid <= bus.o_dp_valid && bus.o_dp_en;
      bus.i_dp_data  <= 4'((int'(bus.o_dp_data) >> sel_offset(bus.o_dp_cmd)) & 15);
    end
  end

  function automatic int sel_offset(input logic [2:0] cmd);
    if (cmd[2] == 1'b0) return 0;
    return int'(cmd[1:0]) + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int exp_cmd(input int s);
    return (s == 0) ? 0 : 4 + (s - 1);
  endfunction

  function automatic logic [19:0] exp_data(input logic [7:0] w, input int st, input int n);
    int r = 0;
    for (int k = 0; k < n; k++) r = r | (((int'(w) >> (st + k)) & 15) << (4 * k));
    return 20'(r);
  endfunction

  // Drive one request from a negedge and follow it to consumption, checking every cycle.
  task automatic run_req(input logic [7:0] w, input int st, input int nm, input int hold_cyc,
                         output logic [19:0] got_data);
    bit bad;
    int n, lat, waited;
    logic [19:0] ed;
    bad = (st > 4) || (nm == 0);
    n   = bad ? 0 : ((nm < 5 - st) ? nm : 5 - st);
    lat = bad ? 1 : n + 2;
    ed  = bad ? 20'h0 : exp_data(w, st, n);
    waited = 0;
    while (bus.o_req_ready !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("req_ready_wait", 32'(bus.o_req_ready), 32'd1);
    bus.i_req_valid = 1'b1;
    bus.i_req_data  = w;
    bus.i_req_start = 3'(st);
    bus.i_req_num   = 3'(nm);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      bus.i_req_valid = 1'b0;
      bus.i_req_data  = 8'($urandom);
      check("req_ready_busy", 32'(bus.o_req_ready), 32'd0);
      if (c <= n) begin
        check("dp_valid", 32'(bus.o_dp_valid), 32'd1);
        check("dp_en", 32'(bus.o_dp_en), 32'd1);
        check("dp_cmd", 32'(bus.o_dp_cmd), 32'(exp_cmd(st + c - 1)));
        check("dp_data", 32'(bus.o_dp_data), 32'(w));
      end else begin
        check("dp_idle", {bus.o_dp_valid, bus.o_dp_en, bus.o_dp_cmd}, 32'd0);
      end
      check("res_valid", 32'(bus.o_res_valid), (c == lat) ? 32'd1 : 32'd0);
    end
    got_data = bus.o_res_data;
    check("res_data", 32'(bus.o_res_data), 32'(ed));
    check("res_cnt", 32'(bus.o_res_cnt), 32'(n));
    check("res_err", 32'(bus.o_res_err), bad ? 32'd1 : 32'd0);
    for (int h = 0; h < hold_cyc; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.o_res_valid), 32'd1);
      check("hold_stable", {bus.o_res_err, bus.o_res_cnt, bus.o_res_data},
            {8'd0, bad, 3'(n), ed});
      check("hold_ready", 32'(bus.o_req_ready), 32'd0);
    end
    bus.i_res_ready = 1'b1;
    @(negedge clk);
    bus.i_res_ready = 1'b0;
    check("consumed_valid", 32'(bus.o_res_valid), 32'd0);
    check("idle_ready", 32'(bus.o_req_ready), 32'd1);
  endtask

  logic [19:0] got;

  initial begin
    bus.i_req_valid = 1'b0;
    bus.i_req_data  = '0;
    bus.i_req_start = '0;
    bus.i_req_num   = '0;
    bus.i_res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs", {bus.o_req_ready, bus.o_dp_valid, bus.o_dp_en, bus.o_dp_cmd,
                       bus.o_res_valid, bus.o_res_cnt, bus.o_res_err}, 32'd0);
    check("rst_data", {bus.o_dp_data, bus.o_res_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.o_req_ready), 32'd1);

    run_req(8'h11, 1, 1, 0, got);
    check("V1_data", 32'(got), 32'h00008);
    run_req(8'hA5, 0, 5, 0, got);
    check("V2_data", 32'(got), 32'hA4925);
    run_req(8'h33, 3, 4, 0, got);
    check("V3_data", 32'(got), 32'h00036);
    run_req(8'h5C, 5, 3, 0, got);
    run_req(8'hA5, 0, 5, 3, got);
    check("V5_data", 32'(got), 32'hA4925);
    run_req(8'h7E, 2, 0, 1, got);

    // V6: reset during the third issue cycle of a full-width request.
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_req_data  = 8'hA5;
    bus.i_req_start = 3'd0;
    bus.i_req_num   = 3'd5;
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("V6_issue3_cmd", 32'(bus.o_dp_cmd), 32'(exp_cmd(2)));
    rst_n = 1'b0;
    @(negedge clk);
    check("V6_rst_outs", {bus.o_req_ready, bus.o_dp_valid, bus.o_dp_en, bus.o_dp_cmd,
                          bus.o_res_valid, bus.o_res_cnt, bus.o_res_err}, 32'd0);
    check("V6_rst_data", {bus.o_dp_data, bus.o_res_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("V6_ready", 32'(bus.o_req_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("V6_no_result", {bus.o_res_valid, bus.o_dp_valid}, 32'd0);
    end

    for (int i = 0; i < 60; i++) begin
      run_req(8'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 3)), got);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bit_sel_window_ctrl.md
BIT_SEL_WINDOW_CTRL -- requirements
Module: bit_sel_window_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the datapath input word width (fixed at 8).
REQ-002 The block SHALL have parameter OUT_DATA_WIDTH, default 4, meaning the selected window width.
REQ-003 The block SHALL have parameter COMMAND_WIDTH, default 3, meaning the selector command width.
REQ-004 The block SHALL have parameter MAX_WIN, default 5, meaning the number of legal offsets (0..4).
REQ-005 The block SHALL have one clock, clk, and a synchronous active-low reset, rst_n.
REQ-006 The block SHALL have the following ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  request accepted when high with i_req_valid
- i_req_data  in  8  word to window
- i_req_start  in  3  first shift offset
- i_req_num  in  3  requested window count
- o_dp_valid  out  1  to selector i_valid
- o_dp_data  out  8  to selector i_data_bus
- o_dp_en  out  1  to selector i_en
- o_dp_cmd  out  3  to selector i_cmd
- i_dp_valid  in  1  from selector o_valid
- i_dp_data  in  4  from selector o_data_bus
- o_res_valid  out  1  result present
- i_res_ready  in  1  result consumed when high with o_res_valid
- o_res_data  out  20  packed windows
- o_res_cnt  out  3  windows in result
- o_res_err  out  1  request was illegal or a capture was lost

Function
REQ-007 The FSM SHALL use states IDLE, ISSUE, DRAIN, HOLD; o_req_ready SHALL be 1 only in IDLE.
REQ-008 On acceptance in cycle T, the block SHALL latch the word and set N = min(i_req_num, 5 - i_req_start).
REQ-009 If i_req_start > 4 or i_req_num == 0, the FSM SHALL go IDLE->HOLD with o_res_cnt=0, o_res_err=1 and o_res_data=0.
REQ-010 Otherwise the FSM SHALL go to ISSUE, driving o_dp_valid=1 and o_dp_en=1 for exactly N cycles, T+1..T+N.
REQ-011 In issue cycle k (k = 0..N-1), the offset SHALL be s = start + k.
REQ-012 o_dp_cmd SHALL be 3'b000 for s = 0 and {1'b1, s-1} for s = 1..4.
REQ-013 o_dp_data SHALL hold the latched word throughout ISSUE.
REQ-014 The selector SHALL be treated as a 1-cycle-latency unit whose output equals bits [3:0] of (word >> s).
REQ-015 Each cycle with i_dp_valid=1 SHALL write i_dp_data into nibble [4j+3:4j] of the result register, where j is a capture counter starting at 0.
REQ-016 Result nibbles at or above N SHALL be 0.
REQ-017 DRAIN SHALL last exactly 1 cycle after the last issue; the FSM SHALL then enter HOLD at T+N+2.
REQ-018 In HOLD, o_res_valid SHALL be 1 and o_res_cnt SHALL equal N.
REQ-019 o_res_err SHALL be 1 in HOLD if the capture count differs from N.
REQ-020 Captures arriving outside ISSUE/DRAIN SHALL be ignored.
REQ-021 HOLD SHALL keep o_res_* stable until i_res_ready=1, then return to IDLE the next cycle.
REQ-022 A new request SHALL NOT be accepted in the same cycle a result is consumed, giving a minimum 1-cycle gap.
REQ-023 In IDLE, DRAIN and HOLD, o_dp_valid, o_dp_en and o_dp_cmd SHALL be 0.

Reset
REQ-024 With rst_n=0 at a clock edge, the FSM SHALL be IDLE and all outputs and counters SHALL be 0 except o_req_ready, which SHALL be 1 from the first cycle after reset.
REQ-025 A reset during ISSUE, DRAIN or HOLD SHALL abort the operation and discard the partial result, with no o_res_valid emitted.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, MAX_WIN, the result width (MAX_WIN*OUT_DATA_WIDTH) and the offset-to-cmd encoding function.
REQ-027 The block SHALL be a single module; the selector SHALL be instantiated only in the bench, with no sub-module inside the block.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- V1: data 0x11, start 1, num 1 -> o_dp_cmd 3'b100 at T+1; o_res_data 0x00008, cnt 1, err 0 at T+3.
- V2: data 0xA5, start 0, num 5 -> cmds 000,100,101,110,111; o_res_data 0xA4925, cnt 5 at T+7.
- V3: data 0x33, start 3, num 4 -> truncated to 2 issues; o_res_data 0x00036, cnt 2, err 0.
- V4: start 5, num 3 -> no o_dp_valid; HOLD at T+1 with cnt 0, err 1.
- V5: V2 with i_res_ready held low 3 cycles in HOLD -> o_res_* stable; o_req_ready=0; IDLE one cycle after ready.
- V6: rst_n=0 during the 3rd issue cycle of V2 -> next cycle all outputs 0 with o_req_ready=0 while rst_n=0; o_req_ready=1 the cycle after rst_n returns high; no result emitted.
